// File: rtl/ex_operand_bypass_if.sv
// Operand bypass bundle: request, forwarding sources and resolved result.
// master drives requests/sources, slave is the bypass stage.
interface ex_operand_bypass_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [XLEN-1:0]   rs1_rf;
    logic [XLEN-1:0]   rs2_rf;
    logic              exm_wr_en;
    logic              exm_is_load;
    logic [REG_AW-1:0] exm_rd;
    logic [XLEN-1:0]   exm_data;
    logic              wb_wr_en;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [1:0]        fwd_sel1;
    logic [1:0]        fwd_sel2;
    logic [31:0]       stall_count;

    modport master (
        output in_valid, rs1_addr, rs2_addr, rs1_rf, rs2_rf,
        output exm_wr_en, exm_is_load, exm_rd, exm_data,
        output wb_wr_en, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, op1, op2,
        input  fwd_sel1, fwd_sel2, stall_count
    );

    modport slave (
        input  in_valid, rs1_addr, rs2_addr, rs1_rf, rs2_rf,
        input  exm_wr_en, exm_is_load, exm_rd, exm_data,
        input  wb_wr_en, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, op1, op2,
        output fwd_sel1, fwd_sel2, stall_count
    );
endinterface

// File: rtl/ex_operand_bypass.sv
// EX operand bypass: forwards from EX/MEM, MEM/WB, retired history or RF,
// stalls on load-use, registers operands behind valid/ready.
module ex_operand_bypass #(
    parameter int XLEN         = 32,
    parameter int REG_AW       = 5,
    parameter int HIST_DEPTH   = 2,
    parameter int STALL_CYCLES = 1
) (
    input logic               clk,
    input logic               rst,
    ex_operand_bypass_if.slave bus
);
    typedef enum logic {RUN, STALL} state_t;

    localparam logic [1:0] SEL_RF   = 2'b00;
    localparam logic [1:0] SEL_WB   = 2'b01;
    localparam logic [1:0] SEL_EXM  = 2'b10;
    localparam logic [1:0] SEL_HIST = 2'b11;
    localparam logic [1:0] STALL_LOAD = 2'(STALL_CYCLES - 1);

    state_t            state;
    state_t            stateNext;
    logic [1:0]        cnt;
    logic [1:0]        cntNext;
    logic              outValid;
    logic [XLEN-1:0]   op1Q;
    logic [XLEN-1:0]   op2Q;
    logic [1:0]        sel1Q;
    logic [1:0]        sel2Q;
    logic [31:0]       stallCnt;

    logic              histValid [HIST_DEPTH];
    logic [REG_AW-1:0] histRd    [HIST_DEPTH];
    logic [XLEN-1:0]   histData  [HIST_DEPTH];

    logic              exmFwd;
    logic [REG_AW-1:0] exmRd;
    logic [XLEN-1:0]   exmData;
    logic              wbWrEn;
    logic [REG_AW-1:0] wbRd;
    logic [XLEN-1:0]   wbData;

    logic [XLEN+1:0]   res1;
    logic [XLEN+1:0]   res2;
    logic              hazard;
    logic              outFree;
    logic              effRun;
    logic              inReady;
    logic              accept;
    logic              stallInc;

    assign exmFwd  = bus.exm_wr_en && !bus.exm_is_load;
    assign exmRd   = bus.exm_rd;
    assign exmData = bus.exm_data;
    assign wbWrEn  = bus.wb_wr_en;
    assign wbRd    = bus.wb_rd;
    assign wbData  = bus.wb_data;

    // Returns {sel, data}; the newest history entry wins on duplicates.
    function automatic logic [XLEN+1:0] resolve(
        input logic [REG_AW-1:0] rs,
        input logic [XLEN-1:0]   rf
    );
        logic [XLEN+1:0] r;
        r = {SEL_RF, rf};
        if (rs != '0) begin
            if (exmFwd && exmRd == rs) begin
                r = {SEL_EXM, exmData};
            end else if (wbWrEn && wbRd == rs) begin
                r = {SEL_WB, wbData};
            end else begin
                for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
                    if (histValid[i] && histRd[i] == rs) begin
                        r = {SEL_HIST, histData[i]};
                    end
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        res1 = resolve(bus.rs1_addr, bus.rs1_rf);
        res2 = resolve(bus.rs2_addr, bus.rs2_rf);
    end

    // A STALL state whose counter has reached 0 re-evaluates like RUN.
    always_comb begin
        hazard = bus.in_valid && bus.exm_wr_en && bus.exm_is_load
              && bus.exm_rd != '0
              && (bus.exm_rd == bus.rs1_addr
               || bus.exm_rd == bus.rs2_addr);
        outFree   = !outValid || bus.out_ready;
        effRun    = (state == RUN) || (cnt == 2'd0);
        inReady   = effRun && !hazard && outFree;
        accept    = bus.in_valid && inReady;
        stallInc  = 1'b0;
        stateNext = RUN;
        cntNext   = 2'd0;
        if (effRun) begin
            if (hazard && outFree) begin
                stateNext = STALL;
                cntNext   = STALL_LOAD;
                stallInc  = 1'b1;
            end
        end else begin
            stateNext = STALL;
            cntNext   = cnt - 2'd1;
            stallInc  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            cnt      <= 2'd0;
            outValid <= 1'b0;
            op1Q     <= '0;
            op2Q     <= '0;
            sel1Q    <= SEL_RF;
            sel2Q    <= SEL_RF;
            stallCnt <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                histValid[i] <= 1'b0;
            end
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (accept) begin
                outValid <= 1'b1;
                sel1Q    <= res1[XLEN+1:XLEN];
                op1Q     <= res1[XLEN-1:0];
                sel2Q    <= res2[XLEN+1:XLEN];
                op2Q     <= res2[XLEN-1:0];
            end else if (bus.out_ready) begin
                outValid <= 1'b0;
            end
            if (stallInc && stallCnt != '1) begin
                stallCnt <= stallCnt + 32'd1;
            end
            for (int i = HIST_DEPTH - 1; i > 0; i--) begin
                histValid[i] <= histValid[i-1];
            end
            histValid[0] <= wbWrEn && wbRd != '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = HIST_DEPTH - 1; i > 0; i--) begin
            histRd[i]   <= histRd[i-1];
            histData[i] <= histData[i-1];
        end
        histRd[0]   <= wbRd;
        histData[0] <= wbData;
    end

    assign bus.in_ready    = inReady;
    assign bus.out_valid   = outValid;
    assign bus.op1         = op1Q;
    assign bus.op2         = op2Q;
    assign bus.fwd_sel1    = sel1Q;
    assign bus.fwd_sel2    = sel2Q;
    assign bus.stall_count = stallCnt;
endmodule

// File: tb/tb_ex_operand_bypass.sv
// Scoreboard bench for ex_operand_bypass: STALL_CYCLES=1 and =3 instances.
module tb_ex_operand_bypass;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  s1;
        logic [1:0]  s2;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    ex_operand_bypass_if #(.XLEN(32), .REG_AW(5)) bus ();
    ex_operand_bypass_if #(.XLEN(32), .REG_AW(5)) bus3 ();

    ex_operand_bypass #(
        .XLEN(32), .REG_AW(5), .HIST_DEPTH(2), .STALL_CYCLES(1)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus)
    );

    ex_operand_bypass #(
        .XLEN(32), .REG_AW(5), .HIST_DEPTH(2), .STALL_CYCLES(3)
    ) dut3 (
        .clk(clk), .rst(rst), .bus(bus3)
    );

    task automatic clr1();
        bus.in_valid = 0; bus.rs1_addr = 0; bus.rs2_addr = 0;
        bus.rs1_rf = 0; bus.rs2_rf = 0;
        bus.exm_wr_en = 0; bus.exm_is_load = 0;
        bus.exm_rd = 0; bus.exm_data = 0;
        bus.wb_wr_en = 0; bus.wb_rd = 0; bus.wb_data = 0;
        bus.out_ready = 1;
    endtask

    task automatic clr3();
        bus3.in_valid = 0; bus3.rs1_addr = 0; bus3.rs2_addr = 0;
        bus3.rs1_rf = 0; bus3.rs2_rf = 0;
        bus3.exm_wr_en = 0; bus3.exm_is_load = 0;
        bus3.exm_rd = 0; bus3.exm_data = 0;
        bus3.wb_wr_en = 0; bus3.wb_rd = 0; bus3.wb_data = 0;
        bus3.out_ready = 1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(
        input logic [4:0] a1, input logic [4:0] a2,
        input logic [31:0] r1, input logic [31:0] r2,
        input logic [31:0] e1, input logic [31:0] e2,
        input logic [1:0] s1, input logic [1:0] s2
    );
        bit ok = 0;
        bus.in_valid = 1; bus.rs1_addr = a1; bus.rs2_addr = a2;
        bus.rs1_rf = r1; bus.rs2_rf = r2;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                sb.push_back('{e1, e2, s1, s2});
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL send_timeout: in_ready=%b, required 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 0;
    endtask

    task automatic test_reset();
        clr1(); clr3();
        rst = 1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 0 || bus.op1 !== 0 || bus.op2 !== 0 ||
            bus.fwd_sel1 !== 0 || bus.fwd_sel2 !== 0 || bus.stall_count !== 0) begin
            fails++;
            $display("FAIL reset1: v=%b op1=%h op2=%h sel=%b/%b sc=%0d, required all 0",
                     bus.out_valid, bus.op1, bus.op2, bus.fwd_sel1, bus.fwd_sel2,
                     bus.stall_count);
        end
        tests++;
        if (bus3.out_valid !== 0 || bus3.op1 !== 0 || bus3.stall_count !== 0) begin
            fails++;
            $display("FAIL reset3: v=%b op1=%h sc=%0d, required 0/0/0",
                     bus3.out_valid, bus3.op1, bus3.stall_count);
        end
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_rf();
        send(5, 6, 32'h11, 32'h22, 32'h11, 32'h22, 2'b00, 2'b00);
        @(negedge clk);
        e = sb.pop_front(); tests++;
        if (bus.out_valid !== 1 || bus.op1 !== e.op1 || bus.op2 !== e.op2 ||
            bus.fwd_sel1 !== e.s1 || bus.fwd_sel2 !== e.s2) begin
            fails++;
            $display("FAIL rf: v=%b op=%h/%h sel=%b/%b, required 1 %h/%h %b/%b",
                     bus.out_valid, bus.op1, bus.op2, bus.fwd_sel1, bus.fwd_sel2,
                     e.op1, e.op2, e.s1, e.s2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_exm_vs_wb();
        bus.exm_wr_en = 1; bus.exm_rd = 5; bus.exm_data = 32'hAAAA;
        bus.wb_wr_en = 1; bus.wb_rd = 5; bus.wb_data = 32'hBBBB;
        send(5, 5, 32'h1, 32'h2, 32'hAAAA, 32'hAAAA, 2'b10, 2'b10);
        clr1();
        @(negedge clk);
        e = sb.pop_front(); tests++;
        if (bus.out_valid !== 1 || bus.op1 !== e.op1 || bus.op2 !== e.op2 ||
            bus.fwd_sel1 !== e.s1 || bus.fwd_sel2 !== e.s2) begin
            fails++;
            $display("FAIL exm_wins: op=%h/%h sel=%b/%b, required %h/%h %b/%b",
                     bus.op1, bus.op2, bus.fwd_sel1, bus.fwd_sel2,
                     e.op1, e.op2, e.s1, e.s2);
        end
        @(posedge clk); #1;
        bus.exm_wr_en = 1; bus.exm_rd = 5; bus.exm_data = 32'hCCCC;
        bus.wb_wr_en = 1; bus.wb_rd = 6; bus.wb_data = 32'hDDDD;
        send(6, 5, 32'h3, 32'h4, 32'hDDDD, 32'hCCCC, 2'b01, 2'b10);
        clr1();
        @(negedge clk);
        e = sb.pop_front(); tests++;
        if (bus.out_valid !== 1 || bus.op1 !== e.op1 || bus.op2 !== e.op2 ||
            bus.fwd_sel1 !== e.s1 || bus.fwd_sel2 !== e.s2) begin
            fails++;
            $display("FAIL per_operand: op=%h/%h sel=%b/%b, required %h/%h %b/%b",
                     bus.op1, bus.op2, bus.fwd_sel1, bus.fwd_sel2,
                     e.op1, e.op2, e.s1, e.s2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_reg();
        bus.exm_wr_en = 1; bus.exm_rd = 0; bus.exm_data = 32'hFFFF;
        bus.wb_wr_en = 1; bus.wb_rd = 0; bus.wb_data = 32'hEEEE;
        send(0, 0, 32'h0, 32'h77, 32'h0, 32'h77, 2'b00, 2'b00);
        clr1();
        @(negedge clk);
        e = sb.pop_front(); tests++;
        if (bus.out_valid !== 1 || bus.op1 !== e.op1 || bus.op2 !== e.op2 ||
            bus.fwd_sel1 !== e.s1 || bus.fwd_sel2 !== e.s2) begin
            fails++;
            $display("FAIL zero_reg: op=%h/%h sel=%b/%b, required %h/%h %b/%b",
                     bus.op1, bus.op2, bus.fwd_sel1, bus.fwd_sel2,
                     e.op1, e.op2, e.s1, e.s2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_use1();
        bus.exm_wr_en = 1; bus.exm_is_load = 1; bus.exm_rd = 7;
        bus.in_valid = 1; bus.rs1_addr = 3; bus.rs1_rf = 32'h33;
        bus.rs2_addr = 7; bus.rs2_rf = 32'hDEAD;
        @(negedge clk); tests++;
        if (bus.in_ready !== 0) begin
            fails++;
            $display("FAIL hazard_ready: in_ready=%b, required 0", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.exm_wr_en = 0; bus.exm_is_load = 0;
        bus.wb_wr_en = 1; bus.wb_rd = 7; bus.wb_data = 32'h1234;
        @(negedge clk); tests++;
        if (bus.in_ready !== 1 || bus.stall_count !== 1) begin
            fails++;
            $display("FAIL stall1: in_ready=%b sc=%0d, required 1 and 1",
                     bus.in_ready, bus.stall_count);
        end
        sb.push_back('{32'h33, 32'h1234, 2'b00, 2'b01});
        @(posedge clk); #1;
        clr1();
        @(negedge clk);
        e = sb.pop_front(); tests++;
        if (bus.out_valid !== 1 || bus.op1 !== e.op1 || bus.op2 !== e.op2 ||
            bus.fwd_sel1 !== e.s1 || bus.fwd_sel2 !== e.s2) begin
            fails++;
            $display("FAIL load_fwd: op=%h/%h sel=%b/%b, required %h/%h %b/%b",
                     bus.op1, bus.op2, bus.fwd_sel1, bus.fwd_sel2,
                     e.op1, e.op2, e.s1, e.s2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_use3();
        int stalls = 0;
        bus3.exm_wr_en = 1; bus3.exm_is_load = 1; bus3.exm_rd = 7;
        bus3.in_valid = 1; bus3.rs1_addr = 0; bus3.rs1_rf = 32'h55;
        bus3.rs2_addr = 7; bus3.rs2_rf = 32'hDEAD;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus3.in_ready === 1'b1) break;
            stalls++;
            @(posedge clk); #1;
            bus3.exm_wr_en = 0; bus3.exm_is_load = 0;
            bus3.wb_wr_en = (c == 0); bus3.wb_rd = 7; bus3.wb_data = 32'h1234;
        end
        tests++;
        if (stalls != 3 || bus3.stall_count !== 3) begin
            fails++;
            $display("FAIL stall3: stall cycles=%0d sc=%0d, required 3 and 3",
                     stalls, bus3.stall_count);
        end
        sb.push_back('{32'h55, 32'h1234, 2'b00, 2'b11});
        @(posedge clk); #1;
        clr3();
        @(negedge clk);
        e = sb.pop_front(); tests++;
        if (bus3.out_valid !== 1 || bus3.op1 !== e.op1 || bus3.op2 !== e.op2 ||
            bus3.fwd_sel1 !== e.s1 || bus3.fwd_sel2 !== e.s2) begin
            fails++;
            $display("FAIL stall3_fwd: op=%h/%h sel=%b/%b, required %h/%h %b/%b",
                     bus3.op1, bus3.op2, bus3.fwd_sel1, bus3.fwd_sel2,
                     e.op1, e.op2, e.s1, e.s2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_history();
        bus.wb_wr_en = 1; bus.wb_rd = 9; bus.wb_data = 32'hC0DE;
        @(posedge clk); #1;
        bus.wb_wr_en = 0;
        send(9, 10, 32'h0, 32'h10, 32'hC0DE, 32'h10, 2'b11, 2'b00);
        @(negedge clk);
        e = sb.pop_front(); tests++;
        if (bus.op1 !== e.op1 || bus.fwd_sel1 !== e.s1 || bus.op2 !== e.op2) begin
            fails++;
            $display("FAIL hist_hit: op1=%h sel1=%b, required %h %b",
                     bus.op1, bus.fwd_sel1, e.op1, e.s1);
        end
        @(posedge clk); #1;
        send(9, 10, 32'h99, 32'h10, 32'h99, 32'h10, 2'b00, 2'b00);
        @(negedge clk);
        e = sb.pop_front(); tests++;
        if (bus.op1 !== e.op1 || bus.fwd_sel1 !== e.s1) begin
            fails++;
            $display("FAIL hist_expired: op1=%h sel1=%b, required %h %b",
                     bus.op1, bus.fwd_sel1, e.op1, e.s1);
        end
        @(posedge clk); #1;
        bus.wb_wr_en = 1; bus.wb_rd = 11; bus.wb_data = 32'hBEEF;
        @(posedge clk); #1;
        bus.wb_wr_en = 0;
        @(posedge clk); #1;
        send(11, 0, 32'h0, 32'h8, 32'hBEEF, 32'h8, 2'b11, 2'b00);
        @(negedge clk);
        e = sb.pop_front(); tests++;
        if (bus.op1 !== e.op1 || bus.fwd_sel1 !== e.s1 || bus.fwd_sel2 !== e.s2) begin
            fails++;
            $display("FAIL hist_oldest: op1=%h sel=%b/%b, required %h %b/%b",
                     bus.op1, bus.fwd_sel1, bus.fwd_sel2, e.op1, e.s1, e.s2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 0;
        send(12, 13, 32'hA1, 32'hA2, 32'hA1, 32'hA2, 2'b00, 2'b00);
        bus.in_valid = 1; bus.rs1_addr = 12; bus.rs2_addr = 13;
        for (int c = 0; c < 3; c++) begin
            bus.rs1_rf = 32'hB1 + c; bus.rs2_rf = 32'hB2 + c;
            @(negedge clk); tests++;
            if (bus.in_ready !== 0 || bus.out_valid !== 1 ||
                bus.op1 !== sb[0].op1 || bus.op2 !== sb[0].op2) begin
                fails++;
                $display("FAIL hold%0d: rdy=%b v=%b op=%h/%h, required 0 1 %h/%h",
                         c, bus.in_ready, bus.out_valid, bus.op1, bus.op2,
                         sb[0].op1, sb[0].op2);
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1;
        bus.rs1_rf = 32'hB1; bus.rs2_rf = 32'hB2;
        @(negedge clk);
        e = sb.pop_front(); tests++;
        if (bus.out_valid !== 1 || bus.op1 !== e.op1 || bus.op2 !== e.op2) begin
            fails++;
            $display("FAIL bp_first: v=%b op=%h/%h, required 1 %h/%h",
                     bus.out_valid, bus.op1, bus.op2, e.op1, e.op2);
        end
        tests++;
        if (bus.in_ready !== 1) begin
            fails++;
            $display("FAIL bp_ready: in_ready=%b, required 1", bus.in_ready);
        end
        sb.push_back('{32'hB1, 32'hB2, 2'b00, 2'b00});
        @(posedge clk); #1;
        bus.in_valid = 0;
        @(negedge clk);
        e = sb.pop_front(); tests++;
        if (bus.out_valid !== 1 || bus.op1 !== e.op1 || bus.op2 !== e.op2) begin
            fails++;
            $display("FAIL bp_second: v=%b op=%h/%h, required 1 %h/%h",
                     bus.out_valid, bus.op1, bus.op2, e.op1, e.op2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_stall();
        bus3.exm_wr_en = 1; bus3.exm_is_load = 1; bus3.exm_rd = 4;
        bus3.in_valid = 1; bus3.rs1_addr = 4; bus3.rs2_addr = 0;
        @(negedge clk); tests++;
        if (bus3.in_ready !== 0) begin
            fails++;
            $display("FAIL rst_hazard: in_ready=%b, required 0", bus3.in_ready);
        end
        @(posedge clk); #1;
        bus3.exm_wr_en = 0; bus3.exm_is_load = 0;
        rst = 1;
        @(negedge clk); tests++;
        if (bus3.in_ready !== 0 || bus3.stall_count !== 4) begin
            fails++;
            $display("FAIL rst_in_stall: in_ready=%b sc=%0d, required 0 and 4",
                     bus3.in_ready, bus3.stall_count);
        end
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk); tests++;
        if (bus3.out_valid !== 0 || bus3.stall_count !== 0 || bus3.in_ready !== 1) begin
            fails++;
            $display("FAIL rst_recover: v=%b sc=%0d rdy=%b, required 0 0 1",
                     bus3.out_valid, bus3.stall_count, bus3.in_ready);
        end
        bus3.in_valid = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_rf();
        test_exm_vs_wb();
        test_zero_reg();
        test_load_use1();
        test_load_use3();
        test_history();
        test_backpressure();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end
endmodule
